bcd_display_scanner: RTL and testbench

BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

---
 rtl/bcd_display_scanner.sv | 132 +++++++++++++
 tb/tb_bcd_display_scanner.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scanner.sv
// Multiplexed 7-segment BCD display scanner with frame-synchronous snapshot,
// leading-zero blanking and PWM brightness gating of the digit drives.
module bcd_display_scanner #(
  parameter int NUM_DIGITS   = 6,
  parameter int PRESCALE     = 1024,
  parameter int BRIGHT_WIDTH = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [BRIGHT_WIDTH-1:0]       brightness,
  input  logic                          lz_blank,
  output logic [6:0]                    led_out,
  output logic                          dp_out,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_index,
  output logic                          frame_start
);

  localparam int IW  = $clog2(NUM_DIGITS);
  localparam int PW  = $clog2(PRESCALE);
  localparam int SUB = PRESCALE >> BRIGHT_WIDTH;

  function automatic logic [6:0] seg7(input logic [3:0] code);
    case (code)
      4'd0:    seg7 = 7'h7E;
      4'd1:    seg7 = 7'h30;
      4'd2:    seg7 = 7'h6D;
      4'd3:    seg7 = 7'h79;
      4'd4:    seg7 = 7'h33;
      4'd5:    seg7 = 7'h5B;
      4'd6:    seg7 = 7'h5F;
      4'd7:    seg7 = 7'h70;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h7B;
      default: seg7 = 7'h01;
    endcase
  endfunction

  logic [PW-1:0]           p, p_nxt, sub_phase;
  logic [IW-1:0]           idx_nxt;
  logic [4*NUM_DIGITS-1:0] snap_d, snap_d_nxt;
  logic [NUM_DIGITS-1:0]   snap_dp, snap_dp_nxt;
  logic [NUM_DIGITS-1:0]   lead_zero, onehot;
  logic                    zero_run, frame_nxt, gate, lead_act, cur_dp;
  logic [3:0]              cur_code;
  logic [6:0]              led_nxt;
  logic                    dp_nxt;
  logic [NUM_DIGITS-1:0]   sel_nxt;

  // Next-state: outputs are registered from these values so they line up
  // with the p/digit_index they describe in the same cycle.
  always_comb begin
    p_nxt       = p;
    idx_nxt     = digit_index;
    snap_d_nxt  = snap_d;
    snap_dp_nxt = snap_dp;
    frame_nxt   = 1'b0;
    if (!en) begin
      snap_d_nxt  = digits_in;
      snap_dp_nxt = dp_in;
    end else if (p == PW'(PRESCALE - 1)) begin
      p_nxt = '0;
      if (digit_index == IW'(NUM_DIGITS - 1)) begin
        idx_nxt     = '0;
        frame_nxt   = 1'b1;
        snap_d_nxt  = digits_in;
        snap_dp_nxt = dp_in;
      end else begin
        idx_nxt = digit_index + IW'(1);
      end
    end else begin
      p_nxt = p + PW'(1);
    end
  end

  always_comb begin
    zero_run  = 1'b1;
    lead_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run     = zero_run & (snap_d_nxt[4*k +: 4] == 4'd0);
      lead_zero[k] = zero_run;
    end
    cur_code = 4'd0;
    cur_dp   = 1'b0;
    lead_act = 1'b0;
    onehot   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_nxt == IW'(k)) begin
        cur_code  = snap_d_nxt[4*k +: 4];
        cur_dp    = snap_dp_nxt[k];
        lead_act  = lead_zero[k] && (k != 0);
        onehot[k] = 1'b1;
      end
    end
    sub_phase = p_nxt / PW'(SUB);
    gate      = (sub_phase <= PW'(brightness));
    led_nxt   = '0;
    dp_nxt    = 1'b0;
    sel_nxt   = '0;
    if (en) begin
      led_nxt = (lz_blank && lead_act) ? 7'h00 : seg7(cur_code);
      dp_nxt  = cur_dp;
      sel_nxt = gate ? onehot : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p           <= '0;
      digit_index <= '0;
      snap_d      <= '0;
      snap_dp     <= '0;
      led_out     <= '0;
      dp_out      <= 1'b0;
      digit_sel   <= '0;
      frame_start <= 1'b0;
    end else begin
      p           <= p_nxt;
      digit_index <= idx_nxt;
      snap_d      <= snap_d_nxt;
      snap_dp     <= snap_dp_nxt;
      led_out     <= led_nxt;
      dp_out      <= dp_nxt;
      digit_sel   <= sel_nxt;
      frame_start <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner (6 digits, 16-cycle slots, 3-bit brightness)
// against a tick-count reference model of the display.
module tb_bcd_display_scanner;

  localparam int ND = 6;
  localparam int PS = 16;
  localparam int BW = 3;
  localparam int FRAME = ND * PS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [4*ND-1:0] digits_in = '0;
  logic [ND-1:0] dp_in = '0;
  logic [BW-1:0] brightness = '0;
  logic          lz_blank = 1'b0;
  logic [6:0]    led_out;
  logic          dp_out;
  logic [ND-1:0] digit_sel;
  logic [2:0]    digit_index;
  logic          frame_start;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] SEG [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B,
    7'h5F, 7'h70, 7'h7F, 7'h7B, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01};

  bcd_display_scanner #(.NUM_DIGITS(ND), .PRESCALE(PS), .BRIGHT_WIDTH(BW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .digits_in(digits_in), .dp_in(dp_in),
    .brightness(brightness), .lz_blank(lz_blank), .led_out(led_out),
    .dp_out(dp_out), .digit_sel(digit_sel), .digit_index(digit_index),
    .frame_start(frame_start));

  always #5 clk = ~clk;

  // Model: m_t counts enabled clock edges since reset; slot and phase follow by arithmetic.
  int              m_t;
  logic [4*ND-1:0] m_snap_d;
  logic [ND-1:0]   m_snap_dp;
  logic            m_on, m_frame, m_lz;
  int              m_b;
  logic [17:0]     exp_bus;

  function automatic logic [17:0] model_out();
    int p, idx, code;
    logic lead, blank;
    logic [ND-1:0] sel;
    logic [2:0] idx3;
    p = m_t % PS;
    idx = (m_t / PS) % ND;
    idx3 = 3'(idx);
    if (!m_on) return {7'h00, 1'b0, 6'b0, idx3, 1'b0};
    code = int'(m_snap_d[4*idx +: 4]);
    lead = 1'b1;
    for (int k = idx; k < ND; k++) if (m_snap_d[4*k +: 4] != 4'd0) lead = 1'b0;
    blank = m_lz && (idx != 0) && lead;
    sel = ((p / (PS >> BW)) <= m_b) ? ND'(1 << idx) : '0;
    return {blank ? 7'h00 : SEG[code], m_snap_dp[idx], sel, idx3, m_frame};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_t = 0; m_snap_d = '0; m_snap_dp = '0; m_on = 1'b0; m_frame = 1'b0;
    end else if (!en) begin
      m_snap_d = digits_in; m_snap_dp = dp_in; m_on = 1'b0; m_frame = 1'b0;
    end else begin
      m_t++;
      m_on = 1'b1;
      m_frame = (m_t % FRAME == 0);
      if (m_frame) begin
        m_snap_d = digits_in; m_snap_dp = dp_in;
      end
    end
    m_b = int'(brightness);
    m_lz = lz_blank;
    #1;
    exp_bus = model_out();
  endtask

  function automatic logic [17:0] dut_bus();
    return {led_out, dp_out, digit_sel, digit_index, frame_start};
  endfunction

  task automatic wait_frame(input string name);
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (frame_start === 1'b1) return;
    end
    checks++; errors++;
    $display("FAIL %s: frame_start not seen within %0d cycles", name, 2 * FRAME);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    en = 1'b1; digits_in = 24'h987654; brightness = 3'd7;
    do_reset();
    checks++;
    if (dut_bus() !== 18'h0) begin
      errors++; $display("FAIL reset_state: got %h want 00000", dut_bus());
    end
    tick();
    checks++;
    if (dut_bus() !== exp_bus || led_out !== 7'h7E) begin
      errors++; $display("FAIL reset_first: got %h want %h", dut_bus(), exp_bus);
    end
  endtask

  task automatic test_scan();
    logic [6:0] slot_led [ND] = '{7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F};
    int gap;
    digits_in = 24'h654321; dp_in = '0; brightness = 3'd7; lz_blank = 1'b0; en = 1'b1;
    wait_frame("scan_sync");
    for (int c = 0; c < FRAME; c++) begin
      checks++;
      if (led_out !== slot_led[c / PS] || digit_sel !== ND'(1 << (c / PS)) || dut_bus() !== exp_bus) begin
        errors++;
        $display("FAIL scan c=%0d: got led=%h sel=%b bus=%h want led=%h sel=%b bus=%h", c,
                 led_out, digit_sel, dut_bus(), slot_led[c / PS], ND'(1 << (c / PS)), exp_bus);
      end
      tick();
    end
    gap = FRAME;
    checks++;
    if (frame_start !== 1'b1) begin
      errors++; $display("FAIL frame_period: frame_start=%b after %0d cycles, want 1", frame_start, gap);
    end
  endtask

  task automatic test_brightness();
    int lvls [2] = '{0, 3};
    int want [2] = '{2, 8};
    int cnt;
    for (int j = 0; j < 2; j++) begin
      brightness = BW'(lvls[j]);
      tick();
      cnt = 0;
      for (int c = 0; c < PS; c++) begin
        tick();
        if (digit_sel !== '0) cnt++;
      end
      checks++;
      if (cnt != want[j]) begin
        errors++; $display("FAIL bright_%0d: active %0d of 16 want %0d", lvls[j], cnt, want[j]);
      end
    end
    brightness = 3'd7;
  endtask

  task automatic test_lz_blank();
    logic [6:0] w1 [ND] = '{7'h7E, 7'h7E, 7'h30, 7'h00, 7'h00, 7'h00};
    logic [6:0] w0 [ND] = '{7'h7E, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    lz_blank = 1'b1; digits_in = 24'h000100;
    wait_frame("lz_sync1");
    for (int c = 0; c < FRAME; c++) begin
      if (c % PS == 8) begin
        checks++;
        if (led_out !== w1[c / PS] || dut_bus() !== exp_bus) begin
          errors++; $display("FAIL lz_100 slot%0d: got %h want %h", c / PS, led_out, w1[c / PS]);
        end
      end
      tick();
    end
    digits_in = 24'h000000;
    wait_frame("lz_sync0");
    for (int c = 0; c < FRAME; c++) begin
      if (c % PS == 8) begin
        checks++;
        if (led_out !== w0[c / PS] || dut_bus() !== exp_bus) begin
          errors++; $display("FAIL lz_zero slot%0d: got %h want %h", c / PS, led_out, w0[c / PS]);
        end
      end
      tick();
    end
    lz_blank = 1'b0;
  endtask

  task automatic test_code_dp();
    logic want_dp;
    digits_in = 24'h0000C0; dp_in = 6'b000100;
    wait_frame("code_sync");
    for (int c = 0; c < FRAME; c++) begin
      if (c == 3 * PS) begin
        digits_in = 24'h999999; dp_in = 6'b111111;
      end
      want_dp = (c / PS == 2);
      checks++;
      if (dp_out !== want_dp || (c / PS == 1 && led_out !== 7'h01) ||
          (c / PS >= 3 && led_out !== 7'h7E) || dut_bus() !== exp_bus) begin
        errors++; $display("FAIL code_dp c=%0d: got led=%h dp=%b bus=%h want dp=%b bus=%h",
                           c, led_out, dp_out, dut_bus(), want_dp, exp_bus);
      end
      tick();
    end
    dp_in = '0;
  endtask

  task automatic test_en_freeze();
    digits_in = 24'h654321;
    wait_frame("freeze_sync");
    for (int c = 0; c < 3 * PS + 5; c++) tick();
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (led_out !== 7'h00 || dp_out !== 1'b0 || digit_sel !== '0 || digit_index !== 3'd3 ||
          frame_start !== 1'b0) begin
        errors++; $display("FAIL en_low c=%0d: got %h want idx 3, outputs 0", c, dut_bus());
      end
    end
    en = 1'b1;
    for (int c = 0; c < FRAME - (3 * PS + 5); c++) begin
      tick();
      checks++;
      if (dut_bus() !== exp_bus || (c < PS - 6 && led_out !== 7'h33) ||
          (c < FRAME - (3 * PS + 5) - 1 && frame_start !== 1'b0)) begin
        errors++; $display("FAIL en_resume c=%0d: got %h want %h", c, dut_bus(), exp_bus);
      end
    end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++; $display("FAIL resume_frame: frame_start=%b want 1", frame_start);
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 40; c++) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (dut_bus() !== 18'h0) begin
      errors++; $display("FAIL reset_mid: got %h want 00000", dut_bus());
    end
    rst_n = 1'b1; digits_in = 24'h123456; lz_blank = 1'b1;
    tick();
    checks++;
    if (led_out !== 7'h7E || digit_index !== 3'd0 || digit_sel !== 6'b000001 || dut_bus() !== exp_bus) begin
      errors++; $display("FAIL reset_release: got %h want %h", dut_bus(), exp_bus);
    end
    lz_blank = 1'b0;
  endtask

  task automatic test_random();
    logic [4*ND-1:0] d;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        d = '0;
        for (int k = 0; k < ND; k++)
          if ($urandom_range(0, 1) == 1) d[4*k +: 4] = 4'($urandom_range(0, 15));
        digits_in = d;
      end
      if ($urandom_range(0, 7) == 0) digits_in = 24'($urandom);
      dp_in = 6'($urandom);
      if ($urandom_range(0, 31) == 0) brightness = 3'($urandom);
      if ($urandom_range(0, 31) == 0) lz_blank = 1'($urandom);
      en = ($urandom_range(0, 15) != 0);
      rst_n = ($urandom_range(0, 599) != 0);
      tick();
      checks++;
      if (dut_bus() !== exp_bus) begin
        errors++; $display("FAIL random c=%0d: got %h want %h", c, dut_bus(), exp_bus);
      end
    end
    rst_n = 1'b1; en = 1'b1;
  endtask

  initial begin
    m_t = 0; m_snap_d = '0; m_snap_dp = '0; m_on = 1'b0; m_frame = 1'b0; m_lz = 1'b0; m_b = 0;
    exp_bus = '0;
    test_reset();
    test_scan();
    test_brightness();
    test_lz_blank();
    test_code_dp();
    test_en_freeze();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
